// File: rtl/serial_byte_capture_pkg.sv
// Shared widths, default frame patterns and the FIFO entry layout for the serial byte capture path.
package serial_byte_capture_pkg;

    localparam int BYTE_W  = 8;
    localparam int TAG_W   = 4;
    localparam int ENTRY_W = BYTE_W + TAG_W;

    localparam logic [BYTE_W-1:0] EVEN_PAT_DEF = 8'hCC;
    localparam logic [BYTE_W-1:0] ODD_PAT_DEF  = 8'hAA;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [BYTE_W-1:0] data;
    } entry_t;

    function automatic logic [BYTE_W-1:0] expected_byte(
        input logic [TAG_W-1:0]  idx,
        input logic [BYTE_W-1:0] even_pat,
        input logic [BYTE_W-1:0] odd_pat
    );
        return idx[0] ? odd_pat : even_pat;
    endfunction

endpackage

// File: rtl/serial_byte_capture_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only when a pop frees a slot on the same edge.
module sync_fifo
    import serial_byte_capture_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LVL_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign level   = count;
    assign dout    = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    // NOTE: storage is left unreset; an entry is only visible after it has been written.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/serial_byte_capture.sv
// LSB-first deserialiser with frame tagging, CC/AA pattern checking and a buffered valid/ready output.
module serial_byte_capture
    import serial_byte_capture_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [BYTE_W-1:0] EVEN_PAT = EVEN_PAT_DEF,
    parameter logic [BYTE_W-1:0] ODD_PAT  = ODD_PAT_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    bit_in,
    input  logic                    bit_en,
    output logic [BYTE_W-1:0]       byte_data,
    output logic [TAG_W-1:0]        byte_tag,
    output logic                    byte_valid,
    input  logic                    byte_ready,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow,
    output logic [7:0]              err_count
);

    logic [2:0]        bit_cnt;
    logic [6:0]        shreg;
    logic [TAG_W-1:0]  frame_idx;
    logic [BYTE_W-1:0] assembled;
    logic              byte_done;
    logic              mismatch;
    logic              pop;
    logic              full;
    logic              empty;
    entry_t            push_entry;
    entry_t            head;

    assign assembled  = {bit_in, shreg};
    assign byte_done  = bit_en && (bit_cnt == 3'd7);
    assign mismatch   = assembled != expected_byte(frame_idx, EVEN_PAT, ODD_PAT);
    assign byte_valid = ~empty;
    assign pop        = byte_valid & byte_ready;
    assign push_entry = '{tag: frame_idx, data: assembled};

    // Gate the head so an empty FIFO presents zeros rather than stale storage.
    assign byte_data = byte_valid ? head.data : '0;
    assign byte_tag  = byte_valid ? head.tag  : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_idx <= '0;
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            if (bit_en) begin
                if (bit_cnt != 3'd7) shreg[bit_cnt] <= bit_in;
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
                frame_idx <= frame_idx + TAG_W'(1);
                if (mismatch && err_count != 8'hFF) err_count <= err_count + 8'd1;
                if (full && !pop) overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (byte_done),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

endmodule
